// File: rtl/miner_pkg.sv
// Shared constants, types and nBits field helpers for the mining datapath.
package miner_pkg;

   localparam int         TARGET_W       = 256;
   localparam int         CNT_W          = 5;
   localparam logic [7:0] NBITS_EXP_BIAS = 8'd3;
   localparam logic [7:0] NBITS_MAX_EXP  = 8'd34;

   localparam int NBITS_EXP_MSB  = 31;
   localparam int NBITS_EXP_LSB  = 24;
   localparam int NBITS_SIGN_BIT = 23;
   localparam int NBITS_MANT_MSB = 22;
   localparam int NBITS_MANT_W   = 23;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic logic [7:0] nbits_exp(input logic [31:0] bits);
      return bits[NBITS_EXP_MSB:NBITS_EXP_LSB];
   endfunction

   function automatic logic [NBITS_MANT_W-1:0] nbits_mant(input logic [31:0] bits);
      return bits[NBITS_MANT_MSB:0];
   endfunction

endpackage

// File: rtl/nbits_target_expander_if.sv
// Compact-difficulty request channel and expanded-target result bundle.
interface nbits_target_expander_if;

   logic [31:0]                   bits_i;
   logic                          bits_valid_i;
   logic                          bits_ready_o;
   logic [miner_pkg::TARGET_W-1:0] target_o;
   logic                          target_valid_o;
   logic                          done_o;
   logic                          err_neg_o;
   logic                          err_ovf_o;

   modport master (
      output bits_i, bits_valid_i,
      input  bits_ready_o, target_o, target_valid_o, done_o, err_neg_o, err_ovf_o
   );

   modport slave (
      input  bits_i, bits_valid_i,
      output bits_ready_o, target_o, target_valid_o, done_o, err_neg_o, err_ovf_o
   );

endinterface

// File: rtl/nbits_decode.sv
// Combinational classification of an nBits word: error flags, shift
// direction and number of byte shifts needed to place the mantissa.
module nbits_decode
   import miner_pkg::*;
(
   input  logic [31:0]      bits,
   output logic             neg,
   output logic             ovf,
   output logic             zero,
   output logic             dir_left,
   output logic [CNT_W-1:0] shift_cnt
);

   logic [7:0]              exp_s;
   logic [NBITS_MANT_W-1:0] mant_s;
   logic [7:0]              dist_s;

   // Decode exponent/mantissa into flags and a byte-shift distance
   always_comb begin
      exp_s    = nbits_exp(bits);
      mant_s   = nbits_mant(bits);
      zero     = (mant_s == 23'd0);
      neg      = bits[NBITS_SIGN_BIT] && !zero;
      // Wider mantissas run out of headroom one exponent step earlier each
      ovf      = !zero &&
                 ((exp_s > NBITS_MAX_EXP) ||
                  ((mant_s > 23'h0000ff) && (exp_s > (NBITS_MAX_EXP - 8'd1))) ||
                  ((mant_s > 23'h00ffff) && (exp_s > (NBITS_MAX_EXP - 8'd2))));
      dir_left = (exp_s >= NBITS_EXP_BIAS);
      if (dir_left) begin
         dist_s = exp_s - NBITS_EXP_BIAS;
      end else begin
         dist_s = NBITS_EXP_BIAS - exp_s;
      end
      if (neg || ovf || zero) begin
         shift_cnt = '0;
      end else begin
         shift_cnt = CNT_W'(dist_s);
      end
   end

endmodule

// File: rtl/nbits_target_expander.sv
// Expands a compact nBits difficulty word into the 256-bit target, one byte
// shift per cycle, holding the result until the next word is accepted.
module nbits_target_expander #(
   parameter int                  TARGET_W     = 256,
   parameter int                  CNT_W        = 5,
   parameter logic [TARGET_W-1:0] RESET_TARGET = '0
)(
   input logic                    clk,
   input logic                    rst_n,
   nbits_target_expander_if.slave bus
);
   import miner_pkg::*;

   state_t                  state_r, state_nxt_s;
   logic [TARGET_W-1:0]     shreg_r, shreg_nxt_s;
   logic [TARGET_W-1:0]     target_r, target_nxt_s;
   logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
   logic                    dir_left_r, dir_left_nxt_s;
   logic                    err_neg_r, err_neg_nxt_s;
   logic                    err_ovf_r, err_ovf_nxt_s;
   logic                    valid_r, valid_nxt_s;
   logic                    done_r, done_nxt_s;
   logic                    accept_s;
   logic [NBITS_MANT_W-1:0] mant_s;
   logic                    dec_neg_s, dec_ovf_s, dec_zero_s, dec_left_s;
   logic [CNT_W-1:0]        dec_cnt_s;

   nbits_decode u_decode (
      .bits      (bus.bits_i),
      .neg       (dec_neg_s),
      .ovf       (dec_ovf_s),
      .zero      (dec_zero_s),
      .dir_left  (dec_left_s),
      .shift_cnt (dec_cnt_s)
   );

   assign accept_s = bus.bits_valid_i && (state_r == IDLE);
   assign mant_s   = nbits_mant(bus.bits_i);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nxt_s = SHIFT;
            else          state_nxt_s = IDLE;
         end
         SHIFT: begin
            if (cnt_r == '0) state_nxt_s = IDLE;
            else             state_nxt_s = SHIFT;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM output/datapath next values
   always_comb begin
      shreg_nxt_s    = shreg_r;
      cnt_nxt_s      = cnt_r;
      dir_left_nxt_s = dir_left_r;
      err_neg_nxt_s  = err_neg_r;
      err_ovf_nxt_s  = err_ovf_r;
      target_nxt_s   = target_r;
      valid_nxt_s    = valid_r;
      done_nxt_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               shreg_nxt_s    = dec_zero_s ? '0 : {{(TARGET_W-NBITS_MANT_W){1'b0}}, mant_s};
               cnt_nxt_s      = dec_cnt_s;
               dir_left_nxt_s = dec_left_s;
               err_neg_nxt_s  = dec_neg_s;
               err_ovf_nxt_s  = dec_ovf_s;
               valid_nxt_s    = 1'b0;
            end else begin
               valid_nxt_s    = valid_r;
            end
         end
         SHIFT: begin
            if (cnt_r != '0) begin
               if (dir_left_r) shreg_nxt_s = {shreg_r[TARGET_W-9:0], 8'h00};
               else            shreg_nxt_s = {8'h00, shreg_r[TARGET_W-1:8]};
               cnt_nxt_s = cnt_r - CNT_W'(1);
            end else begin
               target_nxt_s = (err_neg_r || err_ovf_r) ? RESET_TARGET : shreg_r;
               valid_nxt_s  = 1'b1;
               done_nxt_s   = 1'b1;
            end
         end
         default: begin
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_r    <= '0;
         cnt_r      <= '0;
         dir_left_r <= 1'b0;
         err_neg_r  <= 1'b0;
         err_ovf_r  <= 1'b0;
         target_r   <= RESET_TARGET;
         valid_r    <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         shreg_r    <= shreg_nxt_s;
         cnt_r      <= cnt_nxt_s;
         dir_left_r <= dir_left_nxt_s;
         err_neg_r  <= err_neg_nxt_s;
         err_ovf_r  <= err_ovf_nxt_s;
         target_r   <= target_nxt_s;
         valid_r    <= valid_nxt_s;
         done_r     <= done_nxt_s;
      end
   end

   assign bus.bits_ready_o   = (state_r == IDLE);
   assign bus.target_o       = target_r;
   assign bus.target_valid_o = valid_r;
   assign bus.done_o         = done_r;
   assign bus.err_neg_o      = err_neg_r;
   assign bus.err_ovf_o      = err_ovf_r;

endmodule

// File: tb/tb_nbits_target_expander.sv
// Bench for nbits_target_expander: directed cases plus randomized words
// checked against an arithmetic model of compact-target expansion.
module tb_nbits_target_expander;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   nbits_target_expander_if bus();

   nbits_target_expander dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Value = M * 256^(E-3); invalid when negative or wider than 256 bits
   function automatic void model(input logic [31:0] b, output logic [255:0] t,
                                 output logic neg, output logic ovf, output int lat);
      int e;
      int len;
      e   = int'(b[31:24]);
      len = 0;
      for (int i = 0; i < 23; i++) if (b[i]) len = i + 1;
      neg = b[23] && (len != 0);
      ovf = (len != 0) && (e >= 3) && ((len + 8 * (e - 3)) > 256);
      t   = '0;
      lat = 1;
      if (!neg && !ovf && (len != 0)) begin
         t = 256'(b[22:0]);
         if (e >= 3) begin
            t   = t << (8 * (e - 3));
            lat = e - 3 + 1;
         end else begin
            t   = t >> (8 * (3 - e));
            lat = 3 - e + 1;
         end
      end
   endfunction

   // Called at a negedge in IDLE; returns results observed at completion
   task automatic expand(input logic [31:0] b, output logic [255:0] t, output logic neg,
                         output logic ovf, output int lat, output int done_cnt,
                         output logic dropped);
      bus.bits_i       = b;
      bus.bits_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.bits_valid_i = 1'b0;
      bus.bits_i       = $urandom;
      dropped  = !bus.target_valid_o;
      lat      = 0;
      done_cnt = 0;
      while ((lat < 64) && !bus.target_valid_o) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         if (bus.done_o) done_cnt++;
      end
      t   = bus.target_o;
      neg = bus.err_neg_o;
      ovf = bus.err_ovf_o;
      @(posedge clk);
      @(negedge clk);
      if (bus.done_o) done_cnt++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.bits_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", bus.bits_ready_o); end
      checks++; if (bus.target_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.target_valid_o); end
      checks++; if (bus.target_o !== 256'h0) begin errors++; $display("FAIL reset_target: got %0h want 0", bus.target_o); end
      checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", bus.done_o); end
      checks++; if ({bus.err_neg_o, bus.err_ovf_o} !== 2'b00) begin errors++; $display("FAIL reset_err: got %0b want 00", {bus.err_neg_o, bus.err_ovf_o}); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.bits_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready: got %0b want 1", bus.bits_ready_o); end
   endtask

   task automatic test_directed();
      logic [31:0]  vb   [7];
      logic [255:0] et   [7];
      int           elat [7];
      logic [1:0]   eerr [7];
      logic [255:0] t;
      logic         neg, ovf, dropped;
      int           lat, dc;
      vb   = '{32'h1d00ffff, 32'h03123456, 32'h01123456, 32'h04923456,
               32'h23000001, 32'h2200ffff, 32'h04800000};
      et   = '{{48'h00000000ffff, 208'h0}, 256'h123456, 256'h12, 256'h0, 256'h0, 256'h0, 256'h0};
      elat = '{27, 1, 3, 1, 1, 1, 1};
      eerr = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00};
      for (int i = 0; i < 7; i++) begin
         expand(vb[i], t, neg, ovf, lat, dc, dropped);
         checks++; if (lat !== elat[i]) begin errors++; $display("FAIL dir_latency %08h: got %0d want %0d", vb[i], lat, elat[i]); end
         checks++; if (t !== et[i]) begin errors++; $display("FAIL dir_target %08h: got %0h want %0h", vb[i], t, et[i]); end
         checks++; if ({neg, ovf} !== eerr[i]) begin errors++; $display("FAIL dir_err %08h: got %0b want %0b", vb[i], {neg, ovf}, eerr[i]); end
         checks++; if (dc !== 1) begin errors++; $display("FAIL dir_done_pulses %08h: got %0d want 1", vb[i], dc); end
         checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL dir_valid_drop %08h: got %0b want 1", vb[i], dropped); end
      end
   endtask

   task automatic test_hold();
      logic [255:0] t, et;
      logic         neg, ovf, dropped, eneg, eovf;
      int           lat, dc, elat;
      expand(32'h04923456, t, neg, ovf, lat, dc, dropped);
      for (int i = 0; i < 4; i++) begin
         bus.bits_i = $urandom;
         @(negedge clk);
         checks++; if (bus.err_neg_o !== 1'b1) begin errors++; $display("FAIL hold_err_neg: got %0b want 1", bus.err_neg_o); end
      end
      model(32'h1b0404cb, et, eneg, eovf, elat);
      expand(32'h1b0404cb, t, neg, ovf, lat, dc, dropped);
      checks++; if (lat !== elat) begin errors++; $display("FAIL hold_latency: got %0d want %0d", lat, elat); end
      for (int i = 0; i < 4; i++) begin
         bus.bits_i = $urandom;
         @(negedge clk);
         checks++; if ((bus.target_o !== et) || (bus.target_valid_o !== 1'b1) || (bus.err_neg_o !== 1'b0)) begin
            errors++; $display("FAIL hold_target: got %0h/%0b want %0h/1", bus.target_o, bus.target_valid_o, et);
         end
      end
   endtask

   task automatic test_backpressure();
      int cyc, rdy_bad;
      bus.bits_i       = 32'h1d00ffff;
      bus.bits_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.bits_i = 32'h03000001;
      cyc     = 0;
      rdy_bad = 0;
      while ((cyc < 64) && !bus.done_o) begin
         if (bus.bits_ready_o) rdy_bad++;
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
      checks++; if (cyc !== 27) begin errors++; $display("FAIL bp_latency: got %0d want 27", cyc); end
      checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL bp_ready_low: got %0d ready cycles want 0", rdy_bad); end
      checks++; if (bus.target_o !== {48'h00000000ffff, 208'h0}) begin errors++; $display("FAIL bp_target: got %0h want genesis", bus.target_o); end
      checks++; if (bus.bits_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_after_done: got %0b want 1", bus.bits_ready_o); end
      @(posedge clk);
      @(negedge clk);
      bus.bits_valid_i = 1'b0;
      checks++; if (bus.target_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %0b want 0", bus.target_valid_o); end
      @(posedge clk);
      @(negedge clk);
      checks++; if ((bus.target_valid_o !== 1'b1) || (bus.target_o !== 256'h1) || (bus.done_o !== 1'b1)) begin
         errors++; $display("FAIL b2b_result: got %0h v=%0b d=%0b want 1 v=1 d=1", bus.target_o, bus.target_valid_o, bus.done_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [255:0] t;
      logic         neg, ovf, dropped;
      int           lat, dc;
      @(negedge clk);
      bus.bits_i       = 32'h1d00ffff;
      bus.bits_valid_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.bits_valid_i = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (bus.target_o !== 256'h0) begin errors++; $display("FAIL midrst_target: got %0h want 0", bus.target_o); end
      checks++; if ((bus.target_valid_o !== 1'b0) || (bus.bits_ready_o !== 1'b1) || (bus.done_o !== 1'b0)) begin
         errors++; $display("FAIL midrst_ctrl: got v=%0b r=%0b d=%0b want v=0 r=1 d=0", bus.target_valid_o, bus.bits_ready_o, bus.done_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      expand(32'h03000001, t, neg, ovf, lat, dc, dropped);
      checks++; if ((lat !== 1) || (t !== 256'h1)) begin errors++; $display("FAIL midrst_recover: got lat=%0d t=%0h want lat=1 t=1", lat, t); end
   endtask

   task automatic test_random();
      logic [255:0] t, et;
      logic         neg, ovf, dropped, eneg, eovf;
      int           lat, dc, elat;
      logic [7:0]   e;
      logic [22:0]  m;
      logic [31:0]  b;
      for (int n = 0; n < 60; n++) begin
         e = 8'($urandom_range(0, 40));
         case ($urandom_range(0, 4))
            0:       m = 23'($urandom);
            1:       m = 23'($urandom_range(1, 255));
            2:       m = 23'($urandom_range(256, 65535));
            3:       m = 23'h1 << $urandom_range(0, 22);
            default: m = 23'h0;
         endcase
         b = {e, 1'($urandom_range(0, 1)), m};
         model(b, et, eneg, eovf, elat);
         expand(b, t, neg, ovf, lat, dc, dropped);
         checks++; if ((lat !== elat) || (t !== et)) begin errors++; $display("FAIL rnd_result %08h: got lat=%0d t=%0h want lat=%0d t=%0h", b, lat, t, elat, et); end
         checks++; if ({neg, ovf} !== {eneg, eovf}) begin errors++; $display("FAIL rnd_err %08h: got %0b want %0b", b, {neg, ovf}, {eneg, eovf}); end
         checks++; if ((dc !== 1) || (dropped !== 1'b1)) begin errors++; $display("FAIL rnd_done %08h: got done=%0d drop=%0b want 1/1", b, dc, dropped); end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      bus.bits_i       = 32'h0;
      bus.bits_valid_i = 1'b0;
      rst_n            = 1'b0;
      test_reset();
      test_directed();
      test_hold();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
